// File: rtl/nway_cache_memory_if.sv
// nway_cache_memory_if: request, refill and result bundle for the cache.
// The master drives address, request and refill; the slave returns results.
interface nway_cache_memory_if #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 4,
    parameter int TAG_WIDTH       = 25
);
    localparam int BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE;
    localparam int NUM_SETS     = NUM_BLOCKS / NUM_WAYS;
    localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
    localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
    localparam int WAY_W        = $clog2(NUM_WAYS);

    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] blk_offset;
    logic                    req_valid;
    logic                    req_type;
    logic [WORD_SIZE-1:0]    data_in;
    logic                    refill_en;
    logic [BLOCK_SIZE-1:0]   data_in_mem;
    logic                    done_cache;
    logic                    hit;
    logic [WORD_SIZE-1:0]    data_out;
    logic                    dirty_bit;
    logic [BLOCK_SIZE-1:0]   dirty_block_out;
    logic [TAG_WIDTH-1:0]    evict_tag;
    logic [WAY_W-1:0]        victim_way;

    modport master (
        output tag, index, blk_offset, req_valid, req_type, data_in,
        output refill_en, data_in_mem,
        input  done_cache, hit, data_out, dirty_bit, dirty_block_out,
        input  evict_tag, victim_way
    );

    modport slave (
        input  tag, index, blk_offset, req_valid, req_type, data_in,
        input  refill_en, data_in_mem,
        output done_cache, hit, data_out, dirty_bit, dirty_block_out,
        output evict_tag, victim_way
    );
endinterface

// File: rtl/nway_cache_memory.sv
// nway_cache_memory: N-way set-associative line store with registered results.
// Define CACHE_PLRU_EN for tree-PLRU replacement; default is a per-set FIFO.
module nway_cache_memory #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 4,
    parameter int TAG_WIDTH       = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    nway_cache_memory_if.slave bus
);
    localparam int BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE;
    localparam int NUM_SETS     = NUM_BLOCKS / NUM_WAYS;
    localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
    localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
    localparam int WAY_W        = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]   r_dirty [NUM_SETS];
    logic [TAG_WIDTH-1:0]  r_tag   [NUM_SETS][NUM_WAYS];
    logic [BLOCK_SIZE-1:0] r_data  [NUM_SETS][NUM_WAYS];

    logic                  r_done;
    logic                  r_hit;
    logic [WORD_SIZE-1:0]  r_data_out;
    logic                  r_dirty_bit;
    logic [BLOCK_SIZE-1:0] r_dirty_block;
    logic [TAG_WIDTH-1:0]  r_evict_tag;
    logic [WAY_W-1:0]      r_victim_way;

    logic [INDEX_WIDTH-1:0]  w_idx;
    logic [OFFSET_WIDTH-1:0] w_off;
    logic [NUM_WAYS-1:0]     w_match;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic                    w_any_free;
    logic [WAY_W-1:0]        w_free_way;
    logic [WAY_W-1:0]        w_pol_way;
    logic [WAY_W-1:0]        w_victim;
    logic                    w_do_refill;
    logic                    w_do_req;
    logic                    w_do_hit;
    logic                    w_wr_hit;
    logic [WORD_SIZE-1:0]    w_word;

    assign w_idx       = bus.index;
    assign w_off       = bus.blk_offset;
    assign w_do_refill = bus.refill_en;
    assign w_do_req    = bus.req_valid && !bus.refill_en;
    assign w_hit       = $onehot(w_match);
    assign w_do_hit    = w_do_req && w_hit;
    assign w_wr_hit    = w_do_hit && bus.req_type;
    assign w_victim    = w_any_free ? w_free_way : w_pol_way;
    assign w_word      =
        r_data[w_idx][w_hit_way][int'(w_off)*WORD_SIZE +: WORD_SIZE];

    // Descending scan so the lowest-numbered way wins both searches
    always_comb begin
        w_match    = '0;
        w_hit_way  = '0;
        w_any_free = 1'b0;
        w_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            w_match[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == bus.tag);
            if (!r_valid[w_idx][w]) begin
                w_any_free = 1'b1;
                w_free_way = WAY_W'(w);
            end
            if (w_match[w]) begin
                w_hit_way = WAY_W'(w);
            end
        end
    end

`ifdef CACHE_PLRU_EN
    // Heap-ordered tree, node 1 is the root; bit 0 of each vector is spare
    logic [NUM_WAYS-1:0] r_plru [NUM_SETS];
    logic [NUM_WAYS-1:0] w_plru_next;
    logic [WAY_W-1:0]    w_touch_way;

    assign w_touch_way = w_do_refill ? w_victim : w_hit_way;

    always_comb begin
        logic [WAY_W-1:0] w_node;
        w_node    = WAY_W'(1);
        w_pol_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w_pol_way[WAY_W-1-l] = r_plru[w_idx][w_node];
            w_node = WAY_W'({w_node, r_plru[w_idx][w_node]});
        end
    end

    always_comb begin
        logic [WAY_W-1:0] w_node;
        w_node      = WAY_W'(1);
        w_plru_next = r_plru[w_idx];
        for (int l = 0; l < WAY_W; l++) begin
            w_plru_next[w_node] = ~w_touch_way[WAY_W-1-l];
            w_node = WAY_W'({w_node, w_touch_way[WAY_W-1-l]});
        end
    end
`else
    logic [WAY_W-1:0] r_fifo [NUM_SETS];

    assign w_pol_way = r_fifo[w_idx];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
`ifdef CACHE_PLRU_EN
                r_plru[s]  <= '0;
`else
                r_fifo[s]  <= '0;
`endif
            end
            r_done        <= 1'b0;
            r_hit         <= 1'b0;
            r_data_out    <= '0;
            r_dirty_bit   <= 1'b0;
            r_dirty_block <= '0;
            r_evict_tag   <= '0;
            r_victim_way  <= '0;
        end else begin
            r_done <= w_do_refill || w_do_req;
            if (w_do_refill) begin
                r_valid[w_idx][w_victim] <= 1'b1;
                r_dirty[w_idx][w_victim] <= 1'b0;
            end else if (w_wr_hit) begin
                r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_do_refill || w_do_req) begin
                r_hit         <= w_do_hit;
                r_victim_way  <= w_victim;
                r_data_out    <= w_do_hit ? w_word : '0;
                r_dirty_bit   <= !w_do_hit && r_valid[w_idx][w_victim]
                                 && r_dirty[w_idx][w_victim];
                r_dirty_block <= w_do_hit ? '0 : r_data[w_idx][w_victim];
                r_evict_tag   <= w_do_hit ? '0 : r_tag[w_idx][w_victim];
            end
`ifdef CACHE_PLRU_EN
            if (w_do_refill || w_do_hit) begin
                r_plru[w_idx] <= w_plru_next;
            end
`else
            if (w_do_refill) begin
                r_fifo[w_idx] <= r_fifo[w_idx] + WAY_W'(1);
            end
`endif
        end
    end

    // Tag and data arrays carry no reset; only valid bits qualify them
    always_ff @(posedge clk) begin
        if (rst_n && w_do_refill) begin
            r_tag[w_idx][w_victim]  <= bus.tag;
            r_data[w_idx][w_victim] <= bus.data_in_mem;
        end else if (rst_n && w_wr_hit) begin
            r_data[w_idx][w_hit_way][int'(w_off)*WORD_SIZE +: WORD_SIZE]
                <= bus.data_in;
        end
    end

    assign bus.done_cache      = r_done;
    assign bus.hit             = r_hit;
    assign bus.data_out        = r_data_out;
    assign bus.dirty_bit       = r_dirty_bit;
    assign bus.dirty_block_out = r_dirty_block;
    assign bus.evict_tag       = r_evict_tag;
    assign bus.victim_way      = r_victim_way;
endmodule

// File: tb/tb_nway_cache_memory.sv
// tb_nway_cache_memory: directed and randomized checks against a line-level
// reference model of the cache (default parameters).
module tb_nway_cache_memory;
    localparam int NW    = 4;
    localparam int NSETS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nway_cache_memory_if bus ();

    nway_cache_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit           m_valid [NSETS][NW];
    bit           m_dirty [NSETS][NW];
    logic [24:0]  m_tag   [NSETS][NW];
    logic [127:0] m_data  [NSETS][NW];
    int           m_fifo  [NSETS];
    bit           m_tree  [NSETS][NW];

    bit           e_hit;
    logic [31:0]  e_data;
    int           e_victim;
    bit           e_vvalid;
    bit           e_dirty;
    logic [127:0] e_block;
    logic [24:0]  e_etag;

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++) begin
            m_fifo[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tree[s][w]  = 0;
            end
        end
    endfunction

    function automatic int model_victim(input int ix);
        int n;
        for (int w = 0; w < NW; w++)
            if (!m_valid[ix][w]) return w;
`ifdef CACHE_PLRU_EN
        n = 1;
        while (n < NW) n = 2 * n + int'(m_tree[ix][n]);
        return n - NW;
`else
        n = m_fifo[ix];
        return n;
`endif
    endfunction

    // Walk from the leaf up, pointing each ancestor at the other subtree
    function automatic void model_touch(input int ix, input int way);
        int n;
        n = way + NW;
        while (n > 1) begin
            m_tree[ix][n / 2] = (n % 2 == 0);
            n = n / 2;
        end
    endfunction

    task automatic model_step(input bit rf, input bit rq, input bit wr,
                              input logic [24:0] t, input int ix,
                              input int off, input logic [31:0] din,
                              input logic [127:0] blk);
        int nm, hw, v;
        nm = 0;
        hw = 0;
        for (int w = 0; w < NW; w++)
            if (m_valid[ix][w] && m_tag[ix][w] == t) begin
                nm++;
                hw = w;
            end
        v = model_victim(ix);
        e_victim = v;
        e_vvalid = m_valid[ix][v];
        e_hit = 0;
        e_data = '0;
        e_dirty = 0;
        if (rf) begin
            m_valid[ix][v] = 1;
            m_dirty[ix][v] = 0;
            m_tag[ix][v] = t;
            m_data[ix][v] = blk;
            m_fifo[ix] = (m_fifo[ix] + 1) % NW;
            model_touch(ix, v);
        end else if (rq && nm == 1) begin
            e_hit = 1;
            e_data = m_data[ix][hw][off*32 +: 32];
            if (wr) begin
                m_data[ix][hw][off*32 +: 32] = din;
                m_dirty[ix][hw] = 1;
            end
            model_touch(ix, hw);
        end else if (rq) begin
            e_dirty = m_valid[ix][v] && m_dirty[ix][v];
            e_block = m_data[ix][v];
            e_etag = m_tag[ix][v];
        end
    endtask

    task automatic drive(input bit rf, input bit rq, input bit wr,
                         input logic [24:0] t, input int ix, input int off,
                         input logic [31:0] din, input logic [127:0] blk);
        bus.refill_en = rf;
        bus.req_valid = rq;
        bus.req_type = wr;
        bus.tag = t;
        bus.index = 4'(ix);
        bus.blk_offset = 2'(off);
        bus.data_in = din;
        bus.data_in_mem = blk;
        model_step(rf, rq, wr, t, ix, off, din, blk);
        @(posedge clk);
        @(negedge clk);
        bus.refill_en = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.refill_en = 0; bus.req_valid = 0; bus.req_type = 0;
        bus.tag = '0; bus.index = '0; bus.blk_offset = '0;
        bus.data_in = '0; bus.data_in_mem = '0;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        idle();
        checks++;
        if (bus.done_cache !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", bus.done_cache);
        end
        checks++;
        if ({bus.hit, bus.dirty_bit, bus.data_out, bus.victim_way} !== '0) begin
            errors++; $display("FAIL reset_outs got %b/%b/%h/%0d exp zero",
                bus.hit, bus.dirty_bit, bus.data_out, bus.victim_way);
        end
    endtask

    task automatic test_read_miss();
        drive(0, 1, 0, 25'h1ABCDE, 0, 0, '0, '0);
        checks++;
        if ({bus.done_cache, bus.hit, bus.victim_way, bus.dirty_bit}
            !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL read_miss got d%b h%b v%0d db%b exp d1 h0 v0 db0",
                bus.done_cache, bus.hit, bus.victim_way, bus.dirty_bit);
        end
    endtask

    task automatic test_refill_hit();
        drive(1, 0, 0, 25'h1ABCDE, 0, 0, '0,
              128'hDEADBEEF_55667788_11223344_AABBCCDD);
        checks++;
        if ({bus.done_cache, bus.hit} !== 2'b10) begin
            errors++; $display("FAIL refill_ack got d%b h%b exp d1 h0",
                bus.done_cache, bus.hit);
        end
        drive(0, 1, 0, 25'h1ABCDE, 0, 3, '0, '0);
        checks++;
        if ({bus.hit, bus.data_out} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL read_hit got h%b %h exp h1 deadbeef",
                bus.hit, bus.data_out);
        end
        idle();
        checks++;
        if ({bus.done_cache, bus.hit, bus.data_out}
            !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL done_pulse got d%b h%b %h exp d0 h1 deadbeef",
                bus.done_cache, bus.hit, bus.data_out);
        end
    endtask

    task automatic test_write_dirty();
        drive(0, 1, 1, 25'h1ABCDE, 0, 0, 32'hACF0359E, '0);
        checks++;
        if ({bus.hit, bus.dirty_bit} !== 2'b10) begin
            errors++; $display("FAIL write_hit got h%b db%b exp h1 db0",
                bus.hit, bus.dirty_bit);
        end
        for (int i = 1; i < NW; i++)
            drive(1, 0, 0, 25'h10 + 25'(i), 0, 0, '0, {4{$urandom}});
        drive(0, 1, 0, 25'h99, 0, 0, '0, '0);
        checks++;
        if ({bus.hit, bus.dirty_bit, bus.victim_way} !== {1'b0, 1'b1, 2'd0}) begin
            errors++; $display("FAIL evict_dirty got h%b db%b v%0d exp h0 db1 v0",
                bus.hit, bus.dirty_bit, bus.victim_way);
        end
        checks++;
        if (bus.dirty_block_out[31:0] !== 32'hACF0359E) begin
            errors++; $display("FAIL evict_word got %h exp acf0359e",
                bus.dirty_block_out[31:0]);
        end
        checks++;
        if (bus.dirty_block_out[127:32] !== 96'hDEADBEEF_55667788_11223344) begin
            errors++; $display("FAIL evict_upper got %h exp deadbeef5566778811223344",
                bus.dirty_block_out[127:32]);
        end
        checks++;
        if (bus.evict_tag !== 25'h1ABCDE) begin
            errors++; $display("FAIL evict_tag got %h exp 1abcde", bus.evict_tag);
        end
    endtask

    task automatic test_replacement();
        int exp_v;
`ifdef CACHE_PLRU_EN
        exp_v = 2;
`else
        exp_v = 0;
`endif
        for (int i = 0; i < NW; i++)
            drive(1, 0, 0, 25'h21 + 25'(i), 1, 0, '0, {4{$urandom}});
        drive(0, 1, 0, 25'h21, 1, 0, '0, '0);
        checks++;
        if (bus.hit !== 1'b1) begin
            errors++; $display("FAIL repl_touch got h%b exp h1", bus.hit);
        end
        drive(0, 1, 0, 25'h55, 1, 0, '0, '0);
        checks++;
        if ({bus.hit, bus.victim_way} !== {1'b0, 2'(exp_v)}) begin
            errors++; $display("FAIL repl_victim got h%b v%0d exp h0 v%0d",
                bus.hit, bus.victim_way, exp_v);
        end
    endtask

    task automatic test_collision();
        logic [127:0] b1, b2;
        b1 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        drive(1, 0, 0, 25'h50, 5, 0, '0, b1);
        drive(1, 1, 1, 25'h51, 5, 0, 32'h12345678, b2);
        checks++;
        if ({bus.done_cache, bus.hit} !== 2'b10) begin
            errors++; $display("FAIL collide_ack got d%b h%b exp d1 h0",
                bus.done_cache, bus.hit);
        end
        drive(0, 1, 0, 25'h50, 5, 0, '0, '0);
        checks++;
        if ({bus.hit, bus.data_out} !== {1'b1, b1[31:0]}) begin
            errors++; $display("FAIL collide_nowrite got h%b %h exp h1 %h",
                bus.hit, bus.data_out, b1[31:0]);
        end
        drive(0, 1, 0, 25'h51, 5, 1, '0, '0);
        checks++;
        if ({bus.hit, bus.data_out} !== {1'b1, b2[63:32]}) begin
            errors++; $display("FAIL collide_refill got h%b %h exp h1 %h",
                bus.hit, bus.data_out, b2[63:32]);
        end
    endtask

    task automatic test_random();
        int r, ix, off;
        bit rf, rq, wr;
        logic [24:0] t;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            ix = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            t = 25'h100 + 25'($urandom_range(0, 5));
            rf = (r < 3);
            rq = !rf || ($urandom_range(0, 3) == 0);
            wr = (r >= 3 && r < 6);
            drive(rf, rq, wr, t, ix, off, $urandom,
                  {$urandom, $urandom, $urandom, $urandom});
            checks++;
            if ({bus.done_cache, bus.hit} !== {1'b1, e_hit}) begin
                errors++; $display("FAIL rnd_hit n%0d got d%b h%b exp d1 h%b",
                    n, bus.done_cache, bus.hit, e_hit);
            end
            if (!rf && !(e_hit && wr)) begin
                checks++;
                if (bus.data_out !== e_data) begin
                    errors++; $display("FAIL rnd_data n%0d got %h exp %h",
                        n, bus.data_out, e_data);
                end
            end
            if (!rf) begin
                checks++;
                if (bus.dirty_bit !== e_dirty) begin
                    errors++; $display("FAIL rnd_dirty n%0d got %b exp %b",
                        n, bus.dirty_bit, e_dirty);
                end
            end
            if (!rf && !e_hit) begin
                checks++;
                if (bus.victim_way !== 2'(e_victim)) begin
                    errors++; $display("FAIL rnd_victim n%0d got %0d exp %0d",
                        n, bus.victim_way, e_victim);
                end
            end
            if (!rf && !e_hit && e_vvalid) begin
                checks++;
                if ({bus.evict_tag, bus.dirty_block_out} !== {e_etag, e_block}) begin
                    errors++; $display("FAIL rnd_evict n%0d got %h/%h exp %h/%h",
                        n, bus.evict_tag, bus.dirty_block_out, e_etag, e_block);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 25'h1ABCDE, 0, 0, '0, {4{$urandom}});
        bus.refill_en = 1;
        bus.tag = 25'h77;
        bus.index = 4'd2;
        rst_n = 0;
        model_reset();
        idle();
        bus.refill_en = 0;
        rst_n = 1;
        idle();
        checks++;
        if ({bus.done_cache, bus.hit} !== 2'b00) begin
            errors++; $display("FAIL mid_reset got d%b h%b exp d0 h0",
                bus.done_cache, bus.hit);
        end
        for (int ix = 0; ix < 4; ix++) begin
            drive(0, 1, 0, (ix == 2) ? 25'h77 : 25'h1ABCDE, ix, 0, '0, '0);
            checks++;
            if ({bus.hit, bus.victim_way, bus.dirty_bit} !== 4'b0000) begin
                errors++; $display("FAIL mid_invalid ix%0d got h%b v%0d db%b exp 0",
                    ix, bus.hit, bus.victim_way, bus.dirty_bit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_refill_hit();
        test_write_dirty();
        test_replacement();
        test_collision();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
